// File: rtl/tdc_cap_pkg.sv
// Shared types for the TDC hit-capture block: FSM states, default widths
// and the layout of one captured timestamp entry.
package tdc_cap_pkg;

  localparam int unsigned TDC_CNT_W    = 14;
  localparam int unsigned TDC_MAX_HITS = 4;
  localparam int unsigned TDC_IDX_W    = $clog2(TDC_MAX_HITS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN
  } tdc_state_e;

  typedef struct packed {
    logic [TDC_IDX_W-1:0] idx;
    logic [TDC_CNT_W-1:0] code;
  } tdc_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head is visible on o_dout
// whenever o_empty is low, and reads as zero while empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/tdc_hit_capture.sv
// Captures the coarse counter code on stop-hits inside an armed window,
// tags each with its hit index and buffers them for valid/ready readout.
module tdc_hit_capture
  import tdc_cap_pkg::*;
#(
  parameter int unsigned CNT_W    = TDC_CNT_W,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_HITS = TDC_MAX_HITS
) (
  input  logic                          clk5,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              win_end,
  input  logic [CNT_W-1:0]              counter,
  input  logic                          hit,
  output logic [CNT_W-1:0]              ts_data,
  output logic [$clog2(MAX_HITS)-1:0]   ts_idx,
  output logic                          ts_valid,
  input  logic                          ts_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        fifo_cnt
);

  localparam int unsigned IDX_W = $clog2(MAX_HITS);
  localparam int unsigned EW    = IDX_W + CNT_W;
  localparam logic [IDX_W:0] HIT_LIMIT = (IDX_W+1)'(MAX_HITS);

  tdc_state_e       r_state;
  logic [IDX_W:0]   r_hit_cnt;
  logic             r_overflow;
  logic             r_done;

  logic             w_in_window;
  logic             w_accept;
  logic             w_pop;
  logic             w_drop;
  logic [IDX_W:0]   w_hit_next;
  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;

  assign w_in_window = (counter < win_end);
  assign w_accept    = (r_state == ST_ARMED) && hit && w_in_window;
  assign w_pop       = !w_empty && ts_ready;
  assign w_drop      = w_accept && w_full && !w_pop;
  assign w_hit_next  = r_hit_cnt + 1'b1;

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk5),
    .i_rst   (rst),
    .i_push  (w_accept),
    .i_din   ({r_hit_cnt[IDX_W-1:0], counter}),
    .i_pop   (ts_ready),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_cnt)
  );

  always_ff @(posedge clk5) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hit_cnt  <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_ARMED;
            r_hit_cnt  <= '0;
            r_overflow <= 1'b0;
          end
        end
        ST_ARMED: begin
          // Dropped hits still consume an index so readout can see the gap.
          if (w_accept) begin
            r_hit_cnt <= w_hit_next;
          end
          if ((w_accept && (w_hit_next == HIT_LIMIT)) || !w_in_window) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ts_valid = !w_empty;
  assign ts_idx   = w_head[EW-1:CNT_W];
  assign ts_data  = w_head[CNT_W-1:0];
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: doc/tdc_hit_capture.md
# tdc_hit_capture

Consumer side of the 14-bit pipelined coarse counter: samples the running `counter` code on each stop-hit inside an armed measurement window, tags each sample with its hit index, and buffers samples in a small first-word-fall-through FIFO. The downstream readout drains the FIFO over a valid/ready handshake. The block sits between the coarse counter and the per-channel readout/serializer, in the `clk5` domain.

## Interface
- `CNT_W`, 14, width of the coarse counter code
- `DEPTH`, 8, FIFO entries (power of two, ≥2)
- `MAX_HITS`, 4, hits accepted per window (power of two, ≥2); `IDX_W = log2(MAX_HITS)`

- `clk5`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle arm pulse
- `win_end`  in  CNT_W  window end code, sampled every cycle while ARMED
- `counter`  in  CNT_W  coarse counter code
- `hit`  in  1  stop event, level sampled each edge (one hit per high cycle)
- `ts_data`  out  CNT_W  FIFO head: captured counter code
- `ts_idx`  out  IDX_W  FIFO head: hit index within window (0 = first)
- `ts_valid`  out  1  FIFO non-empty
- `ts_ready`  in  1  downstream accepts head
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on DRAIN→IDLE
- `overflow`  out  1  sticky: a hit was dropped because FIFO full
- `fifo_cnt`  out  log2(DEPTH)+1  current occupancy

## Operation
- States: IDLE, ARMED, DRAIN.
- IDLE: `start`=1 → ARMED; same edge clears hit counter and `overflow`. FIFO contents are not cleared (leftovers still drain).
- `start` in ARMED or DRAIN is ignored.
- ARMED, per edge: hit accepted iff `hit`=1 and `counter < win_end` (unsigned). Accepted hit pushes {hit_cnt, counter} and increments hit_cnt.
- Accepted hit with FIFO full and no simultaneous pop → entry dropped, `overflow` set, hit_cnt still increments.
- Full FIFO with simultaneous pop and push → both occur; no overflow.
- ARMED → DRAIN when hit_cnt reaches MAX_HITS (edge of the last accepted hit) or `counter >= win_end`, whichever first. A hit on the window-end cycle is not captured.
- DRAIN: no pushes. When FIFO empty → IDLE with `done`=1 for exactly that cycle after the edge. DRAIN entered with FIFO already empty → IDLE on the next edge.
- Pop: `ts_valid && ts_ready`. `ts_ready` while empty has no effect. Pops allowed in every state.
- hit_cnt is IDX_W+1 bits; `ts_idx` carries its low IDX_W bits.

## Timing
- Reset (sync, `rst`=1 at edge): state IDLE, FIFO empty, `ts_valid`=0, `ts_data`=0, `ts_idx`=0, `busy`=0, `done`=0, `overflow`=0, `fifo_cnt`=0. Reset mid-window discards all entries.
- Hit sampled at edge k into empty FIFO → `ts_valid`=1 and `ts_data` = `counter` as of edge k, from after edge k (1-cycle latency).
- Captured code is the `counter` value present at the sampling edge; no skew correction.
- `busy` rises after the `start` edge; `fifo_cnt` updates the edge after push/pop.
- `ts_data`/`ts_idx` stable while `ts_valid`=1 and `ts_ready`=0.
- Back-to-back pops: one entry per cycle.

## Structure
- Package `tdc_cap_pkg`: state enum (IDLE/ARMED/DRAIN), `CNT_W` default, entry struct {idx, code}.
- Sub-module `sync_fifo_fwft` (parameterized width/depth, push/pop/full/empty/count, sync active-high reset); top holds FSM, hit counter, window compare, overflow flag.

## Test plan
- Arm, `win_end`=100, hits at `counter`=10,20,30 with `ts_ready`=1 → entries (0,10),(1,20),(2,30); DRAIN at `counter`=100; `done` pulse once FIFO empty.
- Arm, `MAX_HITS`=4, six hits at 5..10 → four entries (0,5)…(3,8); DRAIN on edge of hit 4; hits at 9,10 ignored; `overflow`=0.
- `DEPTH`=2, `MAX_HITS`=4, `ts_ready`=0, hits at 1,2,3 → `fifo_cnt`=2, `overflow`=1, third dropped; later drain yields (0,1),(1,2); next `start` clears `overflow`.
- FIFO full, hit and pop same cycle → `fifo_cnt` unchanged at DEPTH, new entry appended, `overflow`=0.
- Hit on cycle where `counter`=`win_end`=50 → not captured, DRAIN entered; empty FIFO → IDLE next edge with `done`=1.
- `rst`=1 mid-ARMED with 3 entries → next cycle IDLE, `ts_valid`=0, `fifo_cnt`=0, `busy`=0.
